mul_pipe: RTL and testbench
===========================

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width (legal values 8..64).
REQ-002 The block SHALL have parameter STAGES, default 3, giving the accept-to-result latency in cycles (legal values 1..8).
REQ-003 The block SHALL have parameter TAG_W, default 5, giving the width of the destination tag carried with each operation.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all in-flight operations.
REQ-007 in_valid  input  1  an operation is offered this cycle.
REQ-008 in_ready  output  1  the block accepts the offered operation this cycle.
REQ-009 funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-010 a, b  input  XLEN each  rs1 and rs2 operands.
REQ-011 in_tag  input  TAG_W  destination tag that travels with the operation.
REQ-012 out_valid  output  1  result is presented.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 result  output  XLEN  operation result.
REQ-015 out_tag  output  TAG_W  tag of the presented result.
REQ-016 out_illegal  output  1  presented op had funct3[2]=1.
REQ-017 busy  output  1  at least one pipeline stage holds a valid operation.

Function
REQ-018 The block SHALL be fully pipelined: STAGES register stages, each holding valid, funct3, tag and partial/final data, accepting one operation per cycle.
REQ-019 Accept SHALL occur when in_valid && in_ready at a rising edge.
REQ-020 stall SHALL be defined as out_valid && !out_ready; in_ready SHALL equal !stall && !flush.
REQ-021 While stall is high, every stage SHALL hold its contents unchanged.
REQ-022 With out_ready held high, an operation accepted at edge N SHALL present out_valid, result and out_tag after edge N+STAGES-1, i.e. exactly STAGES cycles, and SHALL be retired at the next edge.
REQ-023 Results SHALL be delivered in acceptance order with no loss or duplication under any out_ready pattern.
REQ-024 The product SHALL be formed as a 2*XLEN-bit value from (XLEN+1)-bit extended operands: a sign-extended for MULH and MULHSU, otherwise zero-extended; b sign-extended for MULH only.
REQ-025 result SHALL be product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for MULH, MULHSU and MULHU.
REQ-026 For funct3[2]=1, the operation SHALL traverse the pipeline normally with result = 0 and out_illegal = 1; for legal ops out_illegal SHALL be 0.
REQ-027 result, out_tag and out_illegal SHALL be driven from the final-stage register, with no combinational path from a, b or funct3.
REQ-028 When flush is high at an edge, all stage valid bits SHALL clear, including a presented-but-unconsumed result, and the offered input SHALL NOT be accepted.
REQ-029 With flush high, out_valid SHALL go low after that edge regardless of out_ready.
REQ-030 When the final stage retires and a new op is accepted in the same cycle, both SHALL occur; back-to-back throughput SHALL be one result per cycle.
REQ-031 busy SHALL be the OR of all stage valid bits.

Reset
REQ-032 While reset is high, all stage valid bits SHALL be 0, out_valid, busy and out_illegal SHALL be 0, and result and out_tag SHALL be 0.
REQ-033 Asserting reset mid-operation SHALL discard all in-flight operations; none SHALL appear after reset deasserts.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts, provided flush is low.

Verification
REQ-035 XLEN=32, STAGES=3: MUL a=0xFFFFFFFF, b=0xFFFFFFFF, tag 7 -> out_valid 3 cycles later with result 0x00000001 and out_tag 7.
REQ-036 Same operands with MULH/MULHSU/MULHU issued on consecutive cycles -> consecutive results 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE.
REQ-037 MULH and MULHU with a=b=0x80000000 -> 0x40000000 for both; MUL -> 0x00000000.
REQ-038 Issue 5 ops back-to-back with out_ready low from the first result -> in_ready drops and the pipeline freezes; raising out_ready -> all 5 results drain in order, one per cycle.
REQ-039 flush asserted with 3 ops in flight and in_valid high -> no out_valid afterward, busy=0 next cycle, and the offered op is not accepted.
REQ-040 funct3=3'b101 -> result 0 with out_illegal=1 after STAGES cycles; reset asserted mid-flight -> no output after release.

Source files
------------

// File: rtl/mul_pipe_if.sv
// Handshake bundle for mul_pipe: operation request on the input side and
// tagged result on the output side, plus flush and busy.
interface mul_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             busy;

    modport master (
        output flush, in_valid, funct3, a, b, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, out_illegal, busy
    );

    modport slave (
        input  flush, in_valid, funct3, a, b, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, out_illegal, busy
    );
endinterface

// File: rtl/mul_pipe.sv
// Pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU) with a
// global stall, synchronous flush and a tag carried alongside each operation.
module mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic       clk,
    input  logic       reset,
    mul_pipe_if.slave  bus
);
    localparam int DW = 2 * XLEN;
    // Stage 1 registers raw operands when there is room, so the multiplier
    // sits between two registers instead of hanging off the input pins.
    localparam int MUL_ST = (STAGES > 1) ? 2 : 1;

    function automatic logic [XLEN-1:0] mul_sel(
        input logic [XLEN-1:0] op_a,
        input logic [XLEN-1:0] op_b,
        input logic [2:0]      f3
    );
        logic          a_sgn;
        logic          b_sgn;
        logic [DW+1:0] a_ext;
        logic [DW+1:0] b_ext;
        logic [DW+1:0] prod;
        a_sgn = ((f3[1:0] == 2'b01) || (f3[1:0] == 2'b10)) && op_a[XLEN-1];
        b_sgn = (f3[1:0] == 2'b01) && op_b[XLEN-1];
        a_ext = {{(XLEN+2){a_sgn}}, op_a};
        b_ext = {{(XLEN+2){b_sgn}}, op_b};
        prod  = a_ext * b_ext;
        if (f3[2])
            mul_sel = '0;
        else if (f3[1:0] == 2'b00)
            mul_sel = prod[XLEN-1:0];
        else
            mul_sel = prod[DW-1:XLEN];
    endfunction

    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][2:0]        f3_pipe;
    logic [STAGES:1][TAG_W-1:0]  tag_pipe;
    logic [STAGES:1][DW-1:0]     dat_pipe;

    logic [STAGES:1]             nxt_vld;
    logic [STAGES:1][2:0]        nxt_f3;
    logic [STAGES:1][TAG_W-1:0]  nxt_tag;
    logic [STAGES:1][DW-1:0]     nxt_dat;

    logic stall;
    logic in_rdy;
    logic accept;

    assign stall  = vld_pipe[STAGES] && !bus.out_ready;
    assign in_rdy = !stall && !bus.flush;
    assign accept = bus.in_valid && in_rdy;

    always_comb begin
        nxt_vld = '0;
        nxt_f3  = '0;
        nxt_tag = '0;
        nxt_dat = '0;

        nxt_vld[1] = accept;
        nxt_f3[1]  = bus.funct3;
        nxt_tag[1] = bus.in_tag;
        if (MUL_ST == 1)
            nxt_dat[1] = DW'(mul_sel(bus.a, bus.b, bus.funct3));
        else
            nxt_dat[1] = {bus.a, bus.b};

        for (int s = 2; s <= STAGES; s++) begin
            nxt_vld[s] = vld_pipe[s-1];
            nxt_f3[s]  = f3_pipe[s-1];
            nxt_tag[s] = tag_pipe[s-1];
            if (s == MUL_ST)
                nxt_dat[s] = DW'(mul_sel(dat_pipe[s-1][DW-1:XLEN],
                                         dat_pipe[s-1][XLEN-1:0],
                                         f3_pipe[s-1]));
            else
                nxt_dat[s] = dat_pipe[s-1];
        end
    end

    // The whole pipe advances or freezes as one; bubbles keep their slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            f3_pipe  <= '0;
            tag_pipe <= '0;
            dat_pipe <= '0;
        end else if (bus.flush) begin
            vld_pipe <= '0;
        end else if (!stall) begin
            vld_pipe <= nxt_vld;
            f3_pipe  <= nxt_f3;
            tag_pipe <= nxt_tag;
            dat_pipe <= nxt_dat;
        end
    end

    // Past the multiply stage only the low half carries the selected result.
    logic unused_hi;
    assign unused_hi = ^dat_pipe[STAGES][DW-1:XLEN];

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = vld_pipe[STAGES];
    assign bus.result      = dat_pipe[STAGES][XLEN-1:0];
    assign bus.out_tag     = tag_pipe[STAGES];
    assign bus.out_illegal = vld_pipe[STAGES] && f3_pipe[STAGES][2];
    assign bus.busy        = |vld_pipe;
endmodule

// File: tb/tb_mul_pipe.sv
// Randomised and directed checks of mul_pipe against a queue-based model of
// in-flight operations and their ages.
module tb_mul_pipe;
    localparam int XLEN   = 32;
    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mul_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          age;
    } ent_t;

    ent_t q[$];
    ent_t got[$];
    int   checks = 0;
    int   errors = 0;
    logic last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] f3, input logic [4:0] tag);
        ent_t        e;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        e.tag = tag;
        e.age = 0;
        e.ill = f3[2];
        case (f3)
            3'd0:    p = ua * ub;
            3'd1:    p = sa * sb;
            3'd2:    p = sa * ub;
            3'd3:    p = ua * ub;
            default: p = 64'h0;
        endcase
        if (f3[2])            e.res = 32'h0;
        else if (f3 == 3'd0)  e.res = p[31:0];
        else                  e.res = p[63:32];
        return e;
    endfunction

    // One clock: check in_ready, apply the edge to the model, check outputs.
    task automatic step();
        logic exp_ov, stall;
        ent_t e;
        #1;
        exp_ov = (q.size() > 0) && (q[0].age == STAGES-1);
        stall  = exp_ov && !bus.out_ready;
        chk("in_ready", 64'(bus.in_ready), 64'(!stall && !bus.flush));
        last_acc = bus.in_valid && !stall && !bus.flush;
        e = ref_op(bus.a, bus.b, bus.funct3, bus.in_tag);
        if (bus.out_valid && bus.out_ready && !bus.flush)
            got.push_back('{bus.result, bus.out_tag, bus.out_illegal, 0});
        @(posedge clk);
        #1;
        if (bus.flush) begin
            q.delete();
        end else if (!stall) begin
            if (exp_ov) q.pop_front();
            foreach (q[i]) q[i].age++;
            if (bus.in_valid) q.push_back(e);
        end
        exp_ov = (q.size() > 0) && (q[0].age == STAGES-1);
        chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        chk("busy", 64'(bus.busy), 64'(q.size() != 0));
        if (exp_ov && bus.out_valid) begin
            chk("result", 64'(bus.result), 64'(q[0].res));
            chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
            chk("out_illegal", 64'(bus.out_illegal), 64'(q[0].ill));
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.a        = a;
        bus.b        = b;
        bus.in_tag   = tag;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset_outs();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_illegal", 64'(bus.out_illegal), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_ops [5][2];
        logic [2:0]  exp_f3  [5];
        int          k;
        ent_t        e;

        idle();
        bus.funct3 = 3'd0;
        bus.a      = '0;
        bus.b      = '0;
        bus.in_tag = '0;
        #12;
        chk_reset_outs();
        @(posedge clk); #1;
        reset = 1'b0;

        // MUL of all-ones operands
        got.delete();
        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
        drain(4);
        chk("mul_ones_cnt", 64'(got.size()), 64'd1);
        if (got.size() == 1) begin
            chk("mul_ones_res", 64'(got[0].res), 64'h1);
            chk("mul_ones_tag", 64'(got[0].tag), 64'd7);
        end

        // High-half variants back-to-back
        got.delete();
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        drain(5);
        chk("hi_cnt", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("mulh_ones", 64'(got[0].res), 64'h00000000);
            chk("mulhsu_ones", 64'(got[1].res), 64'hFFFFFFFF);
            chk("mulhu_ones", 64'(got[2].res), 64'hFFFFFFFE);
        end

        // Most-negative operands
        got.delete();
        issue(3'd1, 32'h80000000, 32'h80000000, 5'd4);
        issue(3'd3, 32'h80000000, 32'h80000000, 5'd5);
        issue(3'd0, 32'h80000000, 32'h80000000, 5'd6);
        drain(5);
        chk("min_cnt", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("mulh_min", 64'(got[0].res), 64'h40000000);
            chk("mulhu_min", 64'(got[1].res), 64'h40000000);
            chk("mul_min", 64'(got[2].res), 64'h00000000);
        end

        // Five ops against a stalled consumer, then drain in order
        got.delete();
        for (int i = 0; i < 5; i++) begin
            exp_f3[i]     = 3'(i % 4);
            exp_ops[i][0] = $urandom;
            exp_ops[i][1] = $urandom;
        end
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && !(k == 5 && q.size() == 0); c++) begin
            if (c == 10) bus.out_ready = 1'b1;
            if (k < 5) begin
                bus.in_valid = 1'b1;
                bus.funct3   = exp_f3[k];
                bus.a        = exp_ops[k][0];
                bus.b        = exp_ops[k][1];
                bus.in_tag   = 5'(10 + k);
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            if (last_acc) k++;
        end
        bus.in_valid = 1'b0;
        chk("stall_cnt", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            e = ref_op(exp_ops[i][0], exp_ops[i][1], exp_f3[i], 5'(10 + i));
            chk("stall_tag", 64'(got[i].tag), 64'(e.tag));
            chk("stall_res", 64'(got[i].res), 64'(e.res));
        end

        // Flush with three in flight and a new op offered
        got.delete();
        issue(3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd20);
        issue(3'd0, 32'h00000003, 32'h00000005, 5'd21);
        issue(3'd1, 32'hDEADBEEF, 32'h00000010, 5'd22);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_tag    = 5'd31;
        step();
        chk("flush_busy", 64'(bus.busy), 64'd0);
        idle();
        drain(6);
        chk("flush_none", 64'(got.size()), 64'd0);

        // Illegal funct3 travels through with a zero result
        got.delete();
        issue(3'd5, 32'h11111111, 32'h22222222, 5'd9);
        drain(4);
        chk("ill_cnt", 64'(got.size()), 64'd1);
        if (got.size() == 1) begin
            chk("ill_res", 64'(got[0].res), 64'h0);
            chk("ill_flag", 64'(got[0].ill), 64'd1);
        end

        // Reset while operations are in flight
        got.delete();
        issue(3'd0, 32'h7, 32'h9, 5'd1);
        issue(3'd5, 32'h7, 32'h9, 5'd2);
        reset = 1'b1;
        #2;
        chk_reset_outs();
        q.delete();
        @(posedge clk); #1;
        chk_reset_outs();
        reset = 1'b0;
        drain(6);
        chk("rst_none", 64'(got.size()), 64'd0);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.funct3    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                                        : 3'($urandom_range(0, 3));
            bus.a         = rnd_val();
            bus.b         = rnd_val();
            bus.in_tag    = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 99) < 3);
            step();
        end
        idle();
        drain(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
